logo_motion_ctrl: RTL and testbench

Parametrised per-frame motion engine for the VGA flying-logo path. It detects the start of vertical blanking from the scan counters and divides the frame rate by a programmable ratio. On each qualifying frame it advances a two-axis logo position with per-axis step size and edge bounce. It sits between the VGA timing generator and the logo pixel renderer, and retains the legacy free-running 8-bit frame counter for existing consumers.

---
 rtl/logo_motion_ctrl_pkg.sv | 19 +
 rtl/logo_motion_ctrl_if.sv | 36 +++
 rtl/logo_motion_ctrl_axis_bounce.sv | 75 +++++++
 rtl/logo_motion_ctrl.sv | 103 ++++++++++
 tb/tb_logo_motion_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/logo_motion_ctrl_pkg.sv
// Shared constants for the flying-logo motion engine.
// Pure definitions; no logic, no latency.
// No flow control involved.
package logo_motion_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_OBJ_W    = 64;
    localparam int DEF_OBJ_H    = 48;

    localparam logic DIR_NEG = 1'b0;
    localparam logic DIR_POS = 1'b1;

    // Furthest legal top-left coordinate so the logo stays fully on screen.
    function automatic int span_limit(input int active, input int obj);
        return active - obj;
    endfunction

endpackage

// File: rtl/logo_motion_ctrl_if.sv
// Bundle of scan-counter inputs, motion controls and logo position outputs.
// Wires only; no latency.
// No flow control; the timing generator drives continuously.
interface logo_motion_ctrl_if #(
    parameter int CNT_W  = 10,
    parameter int DIV_W  = 4,
    parameter int STEP_W = 4
);
    logic [CNT_W-1:0]  h_cnt;
    logic [CNT_W-1:0]  v_cnt;
    logic              enable;
    logic [DIV_W-1:0]  div_sel;
    logic [STEP_W-1:0] step_x;
    logic [STEP_W-1:0] step_y;

    logic [CNT_W-1:0]  x_pos;
    logic [CNT_W-1:0]  y_pos;
    logic              dir_x;
    logic              dir_y;
    logic              frame_tick;
    logic              bounce;
    logic              corner;
    logic [7:0]        speed_cnt;

    // Timing generator / controller side.
    modport master (
        output h_cnt, v_cnt, enable, div_sel, step_x, step_y,
        input  x_pos, y_pos, dir_x, dir_y, frame_tick, bounce, corner, speed_cnt
    );

    // Motion engine side.
    modport slave (
        input  h_cnt, v_cnt, enable, div_sel, step_x, step_y,
        output x_pos, y_pos, dir_x, dir_y, frame_tick, bounce, corner, speed_cnt
    );
endinterface

// File: rtl/logo_motion_ctrl_axis_bounce.sv
// One motion axis: position/direction registers with clamp-and-reflect at 0 and LIMIT.
// Position, direction and bounce update one cycle after move_i.
// No backpressure; a move strobe is always accepted.
module axis_bounce
    import logo_motion_pkg::*;
#(
    parameter int CNT_W  = 10,
    parameter int STEP_W = 4,
    parameter int LIMIT  = 576
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              move_i,
    input  logic [STEP_W-1:0] step_i,
    output logic [CNT_W-1:0]  pos_o,
    output logic              dir_o,
    output logic              bounce_o
);
    // One extra bit so pos + step can never wrap before the limit compare.
    localparam int EW = CNT_W + 1;
    localparam logic [EW-1:0] LIMIT_E = EW'(LIMIT);

    logic [CNT_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             bounce_q, bounce_d;
    logic [EW-1:0]    pos_e, step_e, sum_e;

    // Next position: step forward, clamping to the edge and reversing on contact.
    always_comb begin
        pos_e    = {1'b0, pos_q};
        step_e   = EW'(step_i);
        sum_e    = pos_e + step_e;
        pos_d    = pos_q;
        dir_d    = dir_q;
        bounce_d = 1'b0;
        // A zero step is a true hold: no reflection even when parked on an edge.
        if (move_i && (step_i != '0)) begin
            if (dir_q == DIR_POS) begin
                if (sum_e >= LIMIT_E) begin
                    pos_d    = LIMIT_E[CNT_W-1:0];
                    dir_d    = DIR_NEG;
                    bounce_d = 1'b1;
                end else begin
                    pos_d = sum_e[CNT_W-1:0];
                end
            end else begin
                if (pos_e <= step_e) begin
                    pos_d    = '0;
                    dir_d    = DIR_POS;
                    bounce_d = 1'b1;
                end else begin
                    pos_d = CNT_W'(pos_e - step_e);
                end
            end
        end
    end

    // Axis state; bounce is recomputed every cycle so it only lasts one cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pos_q    <= '0;
            dir_q    <= DIR_POS;
            bounce_q <= 1'b0;
        end else begin
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            bounce_q <= bounce_d;
        end
    end

    assign pos_o    = pos_q;
    assign dir_o    = dir_q;
    assign bounce_o = bounce_q;

endmodule

// File: rtl/logo_motion_ctrl.sv
// Per-frame logo motion: vblank-start detect, frame-rate divider, two bouncing axes.
// frame_tick one cycle after the scan event; position/bounce/corner two cycles after.
// No backpressure; scan counters are consumed as they arrive.
module logo_motion_ctrl
    import logo_motion_pkg::*;
#(
    parameter int CNT_W    = 10,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int OBJ_W    = DEF_OBJ_W,
    parameter int OBJ_H    = DEF_OBJ_H,
    parameter int DIV_W    = 4,
    parameter int STEP_W   = 4
) (
    input  logic                pclk,
    input  logic                rst,
    logo_motion_ctrl_if.slave   bus
);
    localparam int X_MAX = span_limit(H_ACTIVE, OBJ_W);
    localparam int Y_MAX = span_limit(V_ACTIVE, OBJ_H);
    localparam logic [CNT_W-1:0] V_EVT = CNT_W'(V_ACTIVE);

    logic             frame_evt;
    logic             frame_tick_q;
    logic [7:0]       speed_cnt_q, speed_cnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             move;
    logic             bounce_x, bounce_y;
    logic [CNT_W-1:0] x_pos, y_pos;
    logic             dir_x, dir_y;

    // First pixel of the first blanking line; true for exactly one cycle per frame.
    assign frame_evt = (bus.h_cnt == '0) && (bus.v_cnt == V_EVT);

    // Divider and legacy counter next state; >= lets a lowered div_sel fire at once.
    always_comb begin
        move        = 1'b0;
        div_cnt_d   = div_cnt_q;
        speed_cnt_d = speed_cnt_q;
        if (frame_tick_q) begin
            speed_cnt_d = speed_cnt_q + 8'd1;
            if (bus.enable) begin
                if (div_cnt_q >= bus.div_sel) begin
                    move      = 1'b1;
                    div_cnt_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
        end
    end

    // Frame tick, legacy frame counter and divider count.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            frame_tick_q <= 1'b0;
            speed_cnt_q  <= '0;
            div_cnt_q    <= '0;
        end else begin
            frame_tick_q <= frame_evt;
            speed_cnt_q  <= speed_cnt_d;
            div_cnt_q    <= div_cnt_d;
        end
    end

    axis_bounce #(
        .CNT_W  (CNT_W),
        .STEP_W (STEP_W),
        .LIMIT  (X_MAX)
    ) u_axis_x (
        .clk_i    (pclk),
        .rst_i    (rst),
        .move_i   (move),
        .step_i   (bus.step_x),
        .pos_o    (x_pos),
        .dir_o    (dir_x),
        .bounce_o (bounce_x)
    );

    axis_bounce #(
        .CNT_W  (CNT_W),
        .STEP_W (STEP_W),
        .LIMIT  (Y_MAX)
    ) u_axis_y (
        .clk_i    (pclk),
        .rst_i    (rst),
        .move_i   (move),
        .step_i   (bus.step_y),
        .pos_o    (y_pos),
        .dir_o    (dir_y),
        .bounce_o (bounce_y)
    );

    assign bus.x_pos      = x_pos;
    assign bus.y_pos      = y_pos;
    assign bus.dir_x      = dir_x;
    assign bus.dir_y      = dir_y;
    assign bus.frame_tick = frame_tick_q;
    assign bus.speed_cnt  = speed_cnt_q;
    assign bus.bounce     = bounce_x | bounce_y;
    assign bus.corner     = bounce_x & bounce_y;

endmodule

// File: tb/tb_logo_motion_ctrl.sv
// Bench for logo_motion_ctrl: vector table, corner sequences, random vs reference model.
// Frames are compressed to three cycles: event, tick, update.
// No backpressure on this block.
module tb_logo_motion_ctrl;
    import logo_motion_pkg::*;

    localparam int CNT_W  = 10;
    localparam int DIV_W  = 4;
    localparam int STEP_W = 4;
    localparam int V_ACT  = 480;
    localparam int X_LIM  = 576;
    localparam int Y_LIM  = 432;

    logic pclk;
    logic rst;

    logo_motion_ctrl_if #(.CNT_W(CNT_W), .DIV_W(DIV_W), .STEP_W(STEP_W)) bus ();

    logo_motion_ctrl #(
        .CNT_W(CNT_W), .H_ACTIVE(640), .V_ACTIVE(V_ACT), .OBJ_W(64), .OBJ_H(48),
        .DIV_W(DIV_W), .STEP_W(STEP_W)
    ) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Values captured by run_frame.
    int g_tick1, g_x1, g_tick2, g_x, g_y, g_dx, g_dy, g_b, g_c, g_spd, g_b3, g_c3;

    task automatic set_ctrl(input bit en, input int ds, input int sx, input int sy);
        bus.enable  = en;
        bus.div_sel = DIV_W'(ds);
        bus.step_x  = STEP_W'(sx);
        bus.step_y  = STEP_W'(sy);
    endtask

    task automatic idle_scan();
        bus.h_cnt = CNT_W'($urandom_range(1, 799));
        bus.v_cnt = CNT_W'($urandom_range(0, 524));
    endtask

    // Called at posedge+1; event cycle, tick cycle, update cycle, then one idle cycle.
    task automatic run_frame();
        bus.h_cnt = '0;
        bus.v_cnt = CNT_W'(V_ACT);
        @(posedge pclk); #1;
        g_tick1 = bus.frame_tick;
        g_x1    = bus.x_pos;
        bus.h_cnt = '0;
        bus.v_cnt = CNT_W'($urandom_range(0, V_ACT - 1));
        @(posedge pclk); #1;
        g_tick2 = bus.frame_tick;
        g_x = bus.x_pos;  g_y = bus.y_pos;
        g_dx = bus.dir_x; g_dy = bus.dir_y;
        g_b = bus.bounce; g_c = bus.corner;
        g_spd = bus.speed_cnt;
        idle_scan();
        @(posedge pclk); #1;
        g_b3 = bus.bounce;
        g_c3 = bus.corner;
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) run_frame();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_scan();
        set_ctrl(1'b0, 0, 0, 0);
        @(posedge pclk); #1;
        rst = 1'b0;
        @(posedge pclk); #1;
    endtask

    // Reference model: positions as plain integers, reflection by signed overshoot.
    int mx, my, mdx, mdy, mdiv, mspd;

    task automatic model_reset();
        mx = 0; my = 0; mdx = 1; mdy = 1; mdiv = 0; mspd = 0;
    endtask

    task automatic model_axis(inout int p, inout int d, input int s, input int lim, output bit b);
        int target;
        b = 1'b0;
        if (s != 0) begin
            target = (d == 1) ? p + s : p - s;
            if (d == 1 && target >= lim) begin
                p = lim; d = 0; b = 1'b1;
            end else if (d == 0 && target <= 0) begin
                p = 0; d = 1; b = 1'b1;
            end else begin
                p = target;
            end
        end
    endtask

    task automatic model_frame(input bit en, input int ds, input int sx, input int sy,
                               output bit b, output bit c);
        bit bx, by, mv;
        bx = 1'b0; by = 1'b0; mv = 1'b0;
        mspd = (mspd + 1) % 256;
        if (en) begin
            if (mdiv >= ds) begin mv = 1'b1; mdiv = 0; end
            else mdiv = mdiv + 1;
        end
        if (mv) begin
            model_axis(mx, mdx, sx, X_LIM, bx);
            model_axis(my, mdy, sy, Y_LIM, by);
        end
        b = bx | by;
        c = bx & by;
    endtask

    typedef struct {
        bit en;
        int ds, sx, sy, nfr;
        int ex, ey, edx, edy, eb, ec, espd;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit mb, mc, en;
        int ds, sx, sy;

        //            en ds sx  sy  nfr  x    y    dx dy b  c  spd
        vecs[0] = '{1'b1, 0,  4,  2,  3,  12,   6, 1, 1, 0, 0,  3};
        vecs[1] = '{1'b1, 0,  8,  6, 72, 576, 432, 0, 0, 1, 1, 72};
        vecs[2] = '{1'b1, 2,  5,  3,  9,  15,   9, 1, 1, 0, 0,  9};
        vecs[3] = '{1'b0, 0,  4,  4,  5,   0,   0, 1, 1, 0, 0,  5};
        vecs[4] = '{1'b1, 1, 15, 15, 80, 561, 267, 0, 0, 0, 0, 80};
        vecs[5] = '{1'b1, 0,  0,  3,  2,   0,   6, 1, 1, 0, 0,  2};

        rst = 1'b0;
        idle_scan();
        set_ctrl(1'b0, 0, 0, 0);
        do_reset();

        // Reset state.
        check("rst x_pos", bus.x_pos, 0);
        check("rst y_pos", bus.y_pos, 0);
        check("rst dir_x", bus.dir_x, 1);
        check("rst dir_y", bus.dir_y, 1);
        check("rst frame_tick", bus.frame_tick, 0);
        check("rst speed_cnt", bus.speed_cnt, 0);

        // Table-driven vectors, each from reset.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            set_ctrl(vecs[v].en, vecs[v].ds, vecs[v].sx, vecs[v].sy);
            run_frames(vecs[v].nfr);
            check($sformatf("vec%0d x_pos", v), g_x, vecs[v].ex);
            check($sformatf("vec%0d y_pos", v), g_y, vecs[v].ey);
            check($sformatf("vec%0d dir_x", v), g_dx, vecs[v].edx);
            check($sformatf("vec%0d dir_y", v), g_dy, vecs[v].edy);
            check($sformatf("vec%0d bounce", v), g_b, vecs[v].eb);
            check($sformatf("vec%0d corner", v), g_c, vecs[v].ec);
            check($sformatf("vec%0d speed_cnt", v), g_spd, vecs[v].espd);
            check($sformatf("vec%0d bounce_after", v), g_b3, 0);
            check($sformatf("vec%0d tick_n1", v), g_tick1, 1);
            check($sformatf("vec%0d tick_n2", v), g_tick2, 0);
        end

        // Asynchronous reset in the middle of a tick cycle, then recovery.
        do_reset();
        set_ctrl(1'b1, 0, 4, 2);
        run_frames(3);
        bus.h_cnt = '0;
        bus.v_cnt = CNT_W'(V_ACT);
        @(posedge pclk); #1;
        idle_scan();
        check("arst pre tick", bus.frame_tick, 1);
        #3 rst = 1'b1;
        #1;
        check("arst x_pos", bus.x_pos, 0);
        check("arst y_pos", bus.y_pos, 0);
        check("arst dir_x", bus.dir_x, 1);
        check("arst dir_y", bus.dir_y, 1);
        check("arst frame_tick", bus.frame_tick, 0);
        check("arst bounce", bus.bounce, 0);
        check("arst corner", bus.corner, 0);
        check("arst speed_cnt", bus.speed_cnt, 0);
        #2 rst = 1'b0;
        @(posedge pclk); #1;
        run_frame();
        check("arst first move x", g_x, 4);
        check("arst first move y", g_y, 2);

        // Update latency: unchanged in the tick cycle, moved the cycle after.
        do_reset();
        set_ctrl(1'b1, 0, 4, 2);
        run_frame();
        check("lat x during tick", g_x1, 0);
        check("lat x after tick", g_x, 4);

        // Right-edge clamp from 572 with step 8, then reflected move.
        do_reset();
        set_ctrl(1'b1, 0, 4, 0);
        run_frames(143);
        check("edge pre x", g_x, 572);
        check("edge pre dir_x", g_dx, 1);
        set_ctrl(1'b1, 0, 8, 0);
        run_frame();
        check("edge x clamp", g_x, 576);
        check("edge dir_x", g_dx, 0);
        check("edge bounce", g_b, 1);
        check("edge corner", g_c, 0);
        check("edge bounce one cycle", g_b3, 0);
        run_frame();
        check("edge reflect x", g_x, 568);
        check("edge no rebounce", g_b, 0);

        // Zero step while parked on both limits: hold, no bounce.
        do_reset();
        set_ctrl(1'b1, 0, 8, 6);
        run_frames(72);
        check("park corner", g_c, 1);
        set_ctrl(1'b1, 0, 0, 0);
        run_frame();
        check("park x", g_x, 576);
        check("park dir_x", g_dx, 0);
        check("park bounce", g_b, 0);

        // Lowering div_sel mid-count fires on the next tick.
        do_reset();
        set_ctrl(1'b1, 5, 4, 4);
        run_frames(3);
        check("div hold x", g_x, 0);
        set_ctrl(1'b1, 1, 4, 4);
        run_frame();
        check("div lowered x", g_x, 4);

        // Legacy counter wrap, independent of enable.
        do_reset();
        set_ctrl(1'b0, 0, 4, 4);
        run_frames(255);
        check("wrap spd 255", g_spd, 255);
        run_frame();
        check("wrap spd 0", g_spd, 0);
        check("wrap x held", g_x, 0);

        // Random controls against the reference model.
        do_reset();
        model_reset();
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 3) != 0);
            ds = $urandom_range(0, 3);
            sx = $urandom_range(0, 15);
            sy = $urandom_range(0, 15);
            set_ctrl(en, ds, sx, sy);
            run_frame();
            model_frame(en, ds, sx, sy, mb, mc);
            check($sformatf("rnd%0d x_pos", i), g_x, mx);
            check($sformatf("rnd%0d y_pos", i), g_y, my);
            check($sformatf("rnd%0d dir_x", i), g_dx, mdx);
            check($sformatf("rnd%0d dir_y", i), g_dy, mdy);
            check($sformatf("rnd%0d bounce", i), g_b, int'(mb));
            check($sformatf("rnd%0d corner", i), g_c, int'(mc));
            check($sformatf("rnd%0d speed_cnt", i), g_spd, mspd);
            check($sformatf("rnd%0d pulse end", i), g_b3 | g_c3, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
